// File: rtl/vcb_seq_ctrl_pkg.sv
// Shared definitions for the VCB4RE sequencer: FSM encoding, default
// parameters and the width of the driven counter.
package vcb_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_CE_DIV  = 8;
  localparam int DEF_N_WRAPS = 2;
  localparam int DEF_WRAP_W  = 8;

  // The VCB4RE is a 4-bit counter, so one wrap spans 16 enabled counts.
  localparam int VCB_WIDTH  = 4;
  localparam int VCB_COUNTS = 1 << VCB_WIDTH;

endpackage

// File: rtl/vcb_seq_ctrl_ce_div_gen.sv
// Clock-enable divider: counts 0..CE_DIV-1 while enabled and flags the last
// count, giving one tick every CE_DIV enabled cycles.
module ce_div_gen
  import vcb_seq_ctrl_pkg::*;
#(
  parameter int CE_DIV = DEF_CE_DIV
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic rst,
  output logic tick
);

  localparam int DW = $clog2(CE_DIV);
  localparam logic [DW-1:0] LAST = DW'(CE_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div <= '0;
    end else if (rst) begin
      div <= '0;
    end else if (en) begin
      div <= (div == LAST) ? '0 : div + DW'(1);
    end
  end

  // Decoded from the register so the enable drops in the same cycle en does.
  assign tick = en && (div == LAST);

endmodule

// File: rtl/vcb_seq_ctrl.sv
// Sequencer for one VCB4RE counter: clears it, drives its clock enable and
// counts wrap-arounds reported on CEO, in one-shot or periodic mode.
module vcb_seq_ctrl
  import vcb_seq_ctrl_pkg::*;
#(
  parameter int CE_DIV  = DEF_CE_DIV,
  parameter int N_WRAPS = DEF_N_WRAPS,
  parameter int WRAP_W  = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic              oneshot,
  input  logic              ceo_in,
  output logic              ce_out,
  output logic              r_out,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wraps
);

  localparam logic [WRAP_W-1:0] LAST_WRAP  = WRAP_W'(N_WRAPS - 1);
  localparam logic [WRAP_W-1:0] FINAL_WRAP = WRAP_W'(N_WRAPS);

  state_t            state;
  state_t            state_nxt;
  logic              mode;
  logic              mode_nxt;
  logic [WRAP_W-1:0] wraps_nxt;
  logic              div_en;
  logic              div_rst;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      mode  <= 1'b0;
      wraps <= '0;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
      wraps <= wraps_nxt;
    end
  end

  // stop is tested before ceo_in so an abort on the final wrap yields no done.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    wraps_nxt = wraps;
    r_out     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    div_en    = 1'b0;
    div_rst   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLEAR;
          mode_nxt  = oneshot;
        end
      end
      CLEAR: begin
        r_out     = 1'b1;
        busy      = 1'b1;
        div_rst   = 1'b1;
        wraps_nxt = '0;
        state_nxt = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        div_en = 1'b1;
        if (stop) begin
          state_nxt = IDLE;
        end else if (ceo_in) begin
          if (mode && (wraps == LAST_WRAP)) begin
            state_nxt = DONE;
            wraps_nxt = FINAL_WRAP;
          end else begin
            wraps_nxt = wraps + WRAP_W'(1);
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  ce_div_gen #(
    .CE_DIV(CE_DIV)
  ) u_div (
    .clk (clk),
    .clr (clr),
    .en  (div_en),
    .rst (div_rst),
    .tick(ce_out)
  );

endmodule

// File: tb/tb_vcb_seq_ctrl.sv
// Bench for vcb_seq_ctrl driving a behavioural VCB4RE; done pulses are
// checked by scoreboard monitors, everything else by directed checks.
module tb_vcb_seq_ctrl;
  import vcb_seq_ctrl_pkg::*;

  typedef struct {
    logic [7:0] wraps;
    logic [3:0] q;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0, stop = 1'b0, oneshot = 1'b0;
  logic       ce_out, r_out, busy, done, ceo;
  logic [7:0] wraps;
  logic [3:0] q = 4'd0;

  logic       start2 = 1'b0, stop2 = 1'b0, oneshot2 = 1'b1;
  logic       ce2, r2, busy2, done2, ceo2;
  logic [7:0] wraps2;
  logic [3:0] q2 = 4'd0;

  int   checks = 0;
  int   passes = 0;
  int   runIdx = 0;
  int   ceBad = 0;
  int   cnt;
  exp_t sb[$];
  exp_t sb2[$];
  exp_t e1, e2;

  always #10 clk = ~clk;

  vcb_seq_ctrl dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .oneshot(oneshot),
    .ceo_in(ceo), .ce_out(ce_out), .r_out(r_out), .busy(busy), .done(done),
    .wraps(wraps)
  );

  vcb_seq_ctrl #(.CE_DIV(2), .N_WRAPS(1), .WRAP_W(8)) dut2 (
    .clk(clk), .clr(clr), .start(start2), .stop(stop2), .oneshot(oneshot2),
    .ceo_in(ceo2), .ce_out(ce2), .r_out(r2), .busy(busy2), .done(done2),
    .wraps(wraps2)
  );

  // Behavioural VCB4RE instances: sync clear has priority over enable.
  always @(posedge clk) begin
    if (r_out) q <= 4'd0;
    else if (ce_out) q <= q + 4'd1;
    if (r2) q2 <= 4'd0;
    else if (ce2) q2 <= q2 + 4'd1;
  end
  assign ceo  = ce_out && (q == 4'(VCB_COUNTS - 1));
  assign ceo2 = ce2 && (q2 == 4'(VCB_COUNTS - 1));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e1 = sb.pop_front();
        checkOutput("done_wraps", {24'd0, wraps}, {24'd0, e1.wraps});
        checkOutput("done_q", {28'd0, q}, {28'd0, e1.q});
        checkOutput("done_busy", {31'd0, busy}, 32'd0);
      end
    end
    if (done2 === 1'b1) begin
      if (sb2.size() == 0) begin
        checkOutput("dut2_unexpected_done", 32'd1, 32'd0);
      end else begin
        e2 = sb2.pop_front();
        checkOutput("dut2_done_wraps", {24'd0, wraps2}, {24'd0, e2.wraps});
        checkOutput("dut2_done_q", {28'd0, q2}, {28'd0, e2.q});
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic p, input logic os);
    start = s;
    stop = p;
    oneshot = os;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  // Advance n RUN cycles, checking ce_out against the 1-in-8 pattern.
  task automatic stepRun(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      runIdx++;
      if (ce_out !== ((runIdx % 8) == 7)) ceBad++;
    end
  endtask

  task automatic runTo(input int target);
    if (target > runIdx) stepRun(target - runIdx);
  endtask

  task automatic startRun(input logic os);
    applyStimulus(1'b1, 1'b0, os);
    checkOutput("clear_r_out", {31'd0, r_out}, 32'd1);
    checkOutput("clear_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("run_r_out", {31'd0, r_out}, 32'd0);
    runIdx = 0;
  endtask

  initial begin
    // Reset state
    #5;
    checkOutput("reset_outputs", {27'd0, ce_out, r_out, busy, done, 1'b0}, 32'd0);
    checkOutput("reset_wraps", {24'd0, wraps}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);

    // One-shot with defaults
    sb.push_back('{wraps: 8'd2, q: 4'd0});
    startRun(1'b1);
    runTo(128);
    checkOutput("oneshot_wraps_128", {24'd0, wraps}, 32'd1);
    runTo(255);
    checkOutput("oneshot_no_early_done", {31'd0, done}, 32'd0);
    stepRun(1);
    checkOutput("oneshot_done_256", {31'd0, done}, 32'd1);
    stepRun(1);
    checkOutput("oneshot_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("oneshot_sb_empty", sb.size(), 32'd0);

    // Back-to-back start, then asynchronous clear mid-run
    startRun(1'b1);
    runTo(150);
    checkOutput("midrun_wraps", {24'd0, wraps}, 32'd1);
    #2;
    clr = 1'b1;
    #1;
    checkOutput("async_clr_outputs", {28'd0, ce_out, r_out, busy, done}, 32'd0);
    checkOutput("async_clr_wraps", {24'd0, wraps}, 32'd0);
    #5;
    clr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_clr_busy", {30'd0, busy, ce_out}, 32'd0);
    checkOutput("post_clr_q_holds", {28'd0, q}, 32'd2);

    // Stop at RUN cycle 50
    startRun(1'b1);
    checkOutput("restart_q_cleared", {28'd0, q}, 32'd0);
    runTo(50);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop_outputs", {30'd0, busy, ce_out}, 32'd0);
    checkOutput("stop_wraps", {24'd0, wraps}, 32'd0);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ce_out !== 1'b0) cnt++;
    end
    checkOutput("stop_no_ce", cnt, 32'd0);
    checkOutput("stop_q_holds", {28'd0, q}, 32'd6);

    // Periodic: 300 wraps, start during RUN ignored
    startRun(1'b0);
    checkOutput("periodic_q_cleared", {28'd0, q}, 32'd0);
    runTo(100);
    start = 1'b1;
    stepRun(1);
    start = 1'b0;
    checkOutput("run_start_ignored_r", {31'd0, r_out}, 32'd0);
    checkOutput("run_start_ignored_busy", {31'd0, busy}, 32'd1);
    runTo(300 * 128);
    checkOutput("periodic_wraps_300", {24'd0, wraps}, 32'd44);
    checkOutput("periodic_ce_spacing", ceBad, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("periodic_stop_wraps", {24'd0, wraps}, 32'd44);

    // start and stop together in IDLE
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("start_stop_r_out", {31'd0, r_out}, 32'd1);
    @(posedge clk);
    #1;
    runIdx = 0;
    sb.push_back('{wraps: 8'd2, q: 4'd0});
    runTo(257);
    checkOutput("start_stop_sb_empty", sb.size(), 32'd0);

    // Back-to-back, stop coincident with the final ceo_in
    startRun(1'b1);
    runTo(255);
    checkOutput("final_ceo_present", {31'd0, ceo}, 32'd1);
    stop = 1'b1;
    stepRun(1);
    stop = 1'b0;
    checkOutput("stop_final_state", {30'd0, busy, done}, 32'd0);
    checkOutput("stop_final_wraps", {24'd0, wraps}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("ce_spacing_total", ceBad, 32'd0);

    // CE_DIV=2, N_WRAPS=1 instance
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    checkOutput("dut2_clear_r", {31'd0, r2}, 32'd1);
    @(posedge clk);
    #1;
    sb2.push_back('{wraps: 8'd1, q: 4'd0});
    cnt = 0;
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk);
      #1;
      if (ce2 !== ((i % 2) == 1) || done2 !== 1'b0) cnt++;
    end
    checkOutput("dut2_ce_alternates", cnt, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("dut2_done_at_32", {30'd0, done2, busy2}, 32'd2);
    @(posedge clk);
    #1;
    checkOutput("dut2_idle", {30'd0, done2, busy2}, 32'd0);
    checkOutput("dut2_sb_empty", sb2.size(), 32'd0);
    checkOutput("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vcb_seq_ctrl.md
# vcb_seq_ctrl

Sequencer for the 4-bit VCB4RE clock-enabled binary counter. It generates the periodic clock-enable pulse stream, issues a synchronous clear before each run, and counts counter wrap-arounds via the counter's CEO output. It supports one-shot runs of a programmed number of wraps and free-running periodic operation. It sits between the control logic and one VCB4RE instance, whose `ce` and `r` inputs it drives.

## Interface
- `CE_DIV`, 8: clocks per `ce_out` pulse; legal range ≥2. 8 gives a 160 ns `ce` period at a 20 ns `clk`.
- `N_WRAPS`, 2: wraps per one-shot run; legal range 1..2^`WRAP_W`.
- `WRAP_W`, 8: width of the wrap counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `start`  in  1  level-sampled run request.
- `stop`  in  1  level-sampled abort.
- `oneshot`  in  1  mode select, latched when a start is accepted: 1 = one-shot, 0 = periodic.
- `ceo_in`  in  1  VCB4RE `CEO` (`ce & TC`).
- `ce_out`  out  1  to VCB4RE `ce`.
- `r_out`  out  1  to VCB4RE `r`, a synchronous clear.
- `busy`  out  1  high in CLEAR or RUN.
- `done`  out  1  one-cycle pulse on one-shot completion.
- `wraps`  out  `WRAP_W`  wraps counted in the current run.

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- **Reset:** while `clr` is high, the controller is held in IDLE and all outputs are 0 (`ce_out`, `r_out`, `busy`, `done`, `wraps`), including the divider count and the latched mode.
- **IDLE:**
  - `start`=1 at an edge → CLEAR.
  - `oneshot` is latched at that edge.
  - `stop` is ignored.
- **CLEAR:** lasts exactly one cycle.
  - `r_out`=1, `wraps`←0, divider←0.
  - Always → RUN.
- **RUN:**
  - Divider counts 0..`CE_DIV`-1 and wraps to 0.
  - `ce_out` = (state==RUN) && (div==`CE_DIV`-1), decoded combinationally from registered state.
  - Each cycle with `ceo_in`=1 increments `wraps`, modulo 2^`WRAP_W`.
  - One-shot mode: `ceo_in`=1 while `wraps`==`N_WRAPS`-1 → DONE, with `wraps` set to `N_WRAPS`.
  - Periodic mode: stays in RUN indefinitely.
  - `stop`=1 → IDLE. The counter is not cleared and `wraps` holds its value.
  - `start` in RUN is ignored.
- **DONE:** `done`=1 for one cycle, then → IDLE. `wraps` holds its final value.
- `ceo_in` is ignored outside RUN.
- **Priorities:**
  - `stop` and the final `ceo_in` in the same RUN cycle: stop wins, giving IDLE with no `done` and `wraps` not incremented.
  - `start` and `stop` together in IDLE: start accepted.
- **Reset mid-run:** an asynchronous `clr` in any state forces IDLE and zero outputs immediately, without waiting for an edge.

## Timing
- `start` sampled at edge k:
  - `busy` and `r_out` high during cycle k..k+1.
  - RUN from edge k+1.
  - First `ce_out` pulse in the `CE_DIV`-th RUN cycle, i.e. ending at edge k+1+`CE_DIV`.
- `ce_out` is high exactly 1 of every `CE_DIV` cycles and never two cycles in a row.
- Counter wrap period is 16·`CE_DIV` clocks. With defaults that is 128 clocks.
- One-shot run latency, from the RUN entry edge to the edge entering DONE: `N_WRAPS`·16·`CE_DIV` clocks. With defaults, 256 clocks; `done` follows in the next cycle.
- `stop` sampled at edge m: `ce_out`=0 and `busy`=0 from edge m onward. No pulse may occur in the cycle after stop.
- After DONE, `start` is accepted at the next edge (back-to-back runs).

## Structure
- **Shared header/package:** state encodings (IDLE=0, CLEAR=1, RUN=2, DONE=3), the default `CE_DIV`/`N_WRAPS`/`WRAP_W`, and the VCB4RE width constant (4, giving 16 counts per wrap).
- **Sub-module `ce_div_gen`:**
  - Inputs: `clk`, `clr`, `en`, sync `rst`.
  - Output: `tick`.
  - Parameter: `CE_DIV`.
  - Implements the divider.
- **Top level:** the FSM, the wrap counter, and output decode.
- **Bench:** one VCB4RE instance with `ce_out`→`ce`, `r_out`→`r`, `CEO`→`ceo_in`.

## Test plan
- **Reset:** `clr` pulsed high for 10 ns at 380 ns mid-run → all outputs 0 within that phase; IDLE on release; counter Q holds (not cleared).
- **One-shot with defaults:**
  - `start` pulse with `oneshot`=1 → `r_out` for 1 cycle.
  - `ce_out` every 8 clocks.
  - `wraps`=1 at 128 RUN clocks.
  - `done` pulse after 256 RUN clocks, with `wraps`=2, counter Q=0, `busy`=0.
- **Periodic:** `oneshot`=0 → no `done`; after 300 wraps `wraps`=44 (300 mod 256); `ce_out` spacing stays 8 clocks.
- **Stop:**
  - `stop` at RUN cycle 50 → `ce_out` never high afterwards; `wraps`=0; counter Q=6 holds.
  - A later `start` → `r_out` clears Q to 0 and counting restarts.
- **Simultaneous events:**
  - `stop` in the same cycle as the final `ceo_in` → no `done`, `wraps`=1.
  - `start`+`stop` together in IDLE → run starts.
  - `start` during RUN → ignored, no extra `r_out`.
- **Parameter sweep:** `CE_DIV`=2, `N_WRAPS`=1 → `done` at 32 RUN clocks; `ce_out` alternates 0/1 in RUN.
